// File: rtl/nibble_addsub_seq_if.sv
// nibble_addsub_seq_if: request/result bundle between a requester and the nibble add/sub engine
interface nibble_addsub_seq_if #(parameter int WIDTH = 16);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cb;
    logic             ovf;

    modport master (output start, op_sub, a, b, input ready, busy, done, result, cb, ovf);
    modport slave  (input start, op_sub, a, b, output ready, busy, done, result, cb, ovf);
endinterface

// File: rtl/nibble_addsub_seq.sv
// nibble_addsub_seq: WIDTH-bit add/subtract computed one nibble per clock on a shared 4-bit slice
module nibble_addsub_seq #(
    parameter int WIDTH = 16
) (
    input logic                clk,
    input logic                rst_n,
    nibble_addsub_seq_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, sub_q, sub_d, cb_q, cb_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]       a_nib, b_nib, s;
    logic             c4, last, ready, busy, done;

    generate
        if (WIDTH % 4 != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_addsub_seq: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    // Subtrahend is already inverted at accept time, so the slice is always a plain adder.
    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];
    assign {c4, s} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    assign last = idx_q == IW'(NIBBLES - 1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: DONE always returns to IDLE, start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        ready = state_q == IDLE;
        busy  = state_q == RUN;
        done  = state_q == DONE;
    end

    // Datapath next state: latch operands on accept, fold one nibble per RUN cycle
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cb_d     = cb_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE && bus.start) begin
            a_d      = bus.a;
            b_d      = bus.op_sub ? ~bus.b : bus.b;
            sub_d    = bus.op_sub;
            carry_d  = bus.op_sub;
            idx_d    = '0;
            result_d = '0;
        end else if (state_q == RUN) begin
            result_d[{idx_q, 2'b00} +: 4] = s;
            carry_d = c4;
            idx_d   = last ? '0 : idx_q + 1'b1;
            if (last) begin
                cb_d  = sub_q ^ c4;
                ovf_d = c4 ^ a_nib[3] ^ b_nib[3] ^ s[3];
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cb_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cb_q     <= cb_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ready  = ready;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
    assign bus.cb     = cb_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_addsub_seq.sv
// tb_nibble_addsub_seq: directed and random checks of the nibble add/sub engine against an arithmetic model
module tb_nibble_addsub_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    nibble_addsub_seq_if #(.WIDTH(16)) bus ();
    nibble_addsub_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands
    task automatic model(input logic s, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic c, output logic v);
        int sr;
        sr = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
        r  = sr[15:0];
        v  = sr > 32767 || sr < -32768;
        c  = s ? int'(x) < int'(y) : int'(x) + int'(y) > 65535;
    endtask

    task automatic check_idle_outputs(input logic [15:0] er, input logic ecb, input logic eov);
        chk("ready", 32'(bus.ready), 1);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("done_idle", 32'(bus.done), 0);
        chk("result_hold", 32'(bus.result), 32'(er));
        chk("cb_hold", 32'(bus.cb), 32'(ecb));
        chk("ovf_hold", 32'(bus.ovf), 32'(eov));
    endtask

    // Called at a negedge while IDLE; returns at the negedge of the first IDLE cycle after DONE
    task automatic do_op(input logic s, input logic [15:0] x, input logic [15:0] y, input bit poke);
        logic [15:0] er;
        logic        ecb, eov;
        model(s, x, y, er, ecb, eov);
        chk("ready_pre", 32'(bus.ready), 1);
        bus.op_sub = s;
        bus.a      = x;
        bus.b      = y;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_run", 32'(bus.busy), 1);
            chk("done_early", 32'(bus.done), 0);
            if (poke) begin
                bus.start  = 1'b1;
                bus.op_sub = ~s;
                bus.a      = (i == 0) ? 16'hFFFF : 16'($urandom);
                bus.b      = (i == 0) ? 16'hFFFF : 16'($urandom);
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("done", 32'(bus.done), 1);
        chk("busy_done", 32'(bus.busy), 0);
        chk("ready_done", 32'(bus.ready), 0);
        chk("result", 32'(bus.result), 32'(er));
        chk("cb", 32'(bus.cb), 32'(ecb));
        chk("ovf", 32'(bus.ovf), 32'(eov));
        if (poke) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_idle_outputs(er, ecb, eov);
    endtask

    initial begin
        logic [15:0] er;
        logic        ecb, eov;
        int          dones, first, prev;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs(16'h0000, 1'b0, 1'b0);

        do_op(1'b1, 16'h1234, 16'h0235, 1'b0);
        do_op(1'b1, 16'h0000, 16'h0001, 1'b0);
        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        do_op(1'b1, 16'h8000, 16'h0001, 1'b0);
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        do_op(1'b1, 16'h1234, 16'h0235, 1'b1);

        // start held high: one operation every 6 cycles
        model(1'b0, 16'h1111, 16'h2222, er, ecb, eov);
        bus.op_sub = 1'b0;
        bus.a      = 16'h1111;
        bus.b      = 16'h2222;
        bus.start  = 1'b1;
        dones = 0;
        first = -1;
        prev  = -1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                chk("b2b_result", 32'(bus.result), 32'(er));
                if (first < 0) first = i;
                else chk("b2b_period", 32'(i - prev), 6);
                prev = i;
            end
        end
        bus.start = 1'b0;
        chk("b2b_dones", 32'(dones), 3);
        chk("b2b_first", 32'(first), 4);

        // asynchronous reset during the 2nd RUN cycle
        bus.op_sub = 1'b1;
        bus.a      = 16'h1234;
        bus.b      = 16'h0235;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs(16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(bus.done), 0);
        end
        do_op(1'b0, 16'h00FF, 16'h0001, 1'b0);

        for (int i = 0; i < 40; i++)
            do_op(1'($urandom), 16'($urandom), 16'($urandom), i % 5 == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
